// File: rtl/door_direction_detector.sv
// Two-beam doorway direction detector: synchronizes and debounces both beams,
// then tracks the break order to emit one-cycle entry/exit pulses.
module door_direction_detector #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       beam_outer,
   input  logic       beam_inner,
   output logic       enter_pulse,
   output logic       exit_pulse,
   output logic       busy,
   output logic       timeout_err,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      E1         = 4'd1,
      E2         = 4'd2,
      E3         = 4'd3,
      X1         = 4'd4,
      X2         = 4'd5,
      X3         = 4'd6,
      WAIT_CLEAR = 4'd7
   } state_t;

   localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   // Bit 1 carries the outer beam, bit 0 the inner beam, so db is P directly.
   logic [1:0]  sync1, sync2, db;
   logic [7:0]  db_cnt [2];
   logic [15:0] dwell;
   state_t      state, state_nxt;
   logic        enter_nxt, exit_nxt, tmo_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1     <= 2'b00;
         sync2     <= 2'b00;
         db        <= 2'b00;
         db_cnt[0] <= 8'd0;
         db_cnt[1] <= 8'd0;
      end else begin
         sync1 <= {beam_outer, beam_inner};
         sync2 <= sync1;
         for (int b = 0; b < 2; b++) begin
            if (sync2[b] != db[b]) begin
               if (db_cnt[b] == DB_LAST) begin
                  db[b]     <= sync2[b];
                  db_cnt[b] <= 8'd0;
               end else begin
                  db_cnt[b] <= db_cnt[b] + 8'd1;
               end
            end else begin
               db_cnt[b] <= 8'd0;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      enter_nxt = 1'b0;
      exit_nxt  = 1'b0;
      tmo_nxt   = 1'b0;
      case (state)
         IDLE: begin
            case (db)
               2'b10:   state_nxt = E1;
               2'b01:   state_nxt = X1;
               2'b11:   state_nxt = WAIT_CLEAR;
               default: state_nxt = IDLE;
            endcase
         end
         E1: begin
            case (db)
               2'b11:   state_nxt = E2;
               2'b00:   state_nxt = IDLE;
               2'b01:   state_nxt = WAIT_CLEAR;
               default: state_nxt = E1;
            endcase
         end
         E2: begin
            case (db)
               2'b01:   state_nxt = E3;
               2'b10:   state_nxt = E1;
               2'b00:   state_nxt = IDLE;
               default: state_nxt = E2;
            endcase
         end
         E3: begin
            case (db)
               2'b00: begin
                  state_nxt = IDLE;
                  enter_nxt = 1'b1;
               end
               2'b11:   state_nxt = E2;
               2'b10:   state_nxt = WAIT_CLEAR;
               default: state_nxt = E3;
            endcase
         end
         X1: begin
            case (db)
               2'b11:   state_nxt = X2;
               2'b00:   state_nxt = IDLE;
               2'b10:   state_nxt = WAIT_CLEAR;
               default: state_nxt = X1;
            endcase
         end
         X2: begin
            case (db)
               2'b10:   state_nxt = X3;
               2'b01:   state_nxt = X1;
               2'b00:   state_nxt = IDLE;
               default: state_nxt = X2;
            endcase
         end
         X3: begin
            case (db)
               2'b00: begin
                  state_nxt = IDLE;
                  exit_nxt  = 1'b1;
               end
               2'b11:   state_nxt = X2;
               2'b01:   state_nxt = WAIT_CLEAR;
               default: state_nxt = X3;
            endcase
         end
         WAIT_CLEAR: begin
            if (db == 2'b00) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A stalled sequence is the only way dwell can reach the limit.
      if (state_nxt == state && state != IDLE && state != WAIT_CLEAR &&
          dwell == TO_LAST) begin
         state_nxt = WAIT_CLEAR;
         tmo_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         dwell       <= 16'd0;
         enter_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         enter_pulse <= enter_nxt;
         exit_pulse  <= exit_nxt;
         busy        <= (state_nxt != IDLE);
         timeout_err <= tmo_nxt;
         if (state == IDLE || state_nxt != state) dwell <= 16'd0;
         else if (dwell != 16'hFFFF)              dwell <= dwell + 16'd1;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_door_direction_detector.sv
// Directed bench for door_direction_detector with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=64; a negedge monitor logs pulses and state changes.
module tb_door_direction_detector;

   localparam logic [3:0] S_IDLE = 4'd0, S_E1 = 4'd1, S_E2 = 4'd2, S_E3 = 4'd3;
   localparam logic [3:0] S_X1 = 4'd4, S_WC = 4'd7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       beam_outer = 1'b0;
   logic       beam_inner = 1'b0;
   logic       enter_pulse, exit_pulse, busy, timeout_err;
   logic [3:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int enter_cnt, exit_cnt, tmo_cnt, busy_cnt, both_cnt;
   int enter_cyc, exit_cyc, tmo_cyc, busy_rise_cyc;
   logic       busy_prev;
   logic [3:0] prev_state;
   logic [3:0] st_q[$];
   int         st_cyc_q[$];

   door_direction_detector #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .reset(reset), .beam_outer(beam_outer), .beam_inner(beam_inner),
      .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .busy(busy),
      .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (enter_pulse) begin enter_cnt++; enter_cyc = cyc; end
      if (exit_pulse)  begin exit_cnt++;  exit_cyc  = cyc; end
      if (timeout_err) begin tmo_cnt++;   tmo_cyc   = cyc; end
      if (enter_pulse && exit_pulse) both_cnt++;
      if (busy) busy_cnt++;
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      busy_prev = busy;
      if (dbg_state !== prev_state) begin
         st_q.push_back(dbg_state);
         st_cyc_q.push_back(cyc);
         prev_state = dbg_state;
      end
   end

   task automatic clear_mon();
      enter_cnt = 0; exit_cnt = 0; tmo_cnt = 0; busy_cnt = 0; both_cnt = 0;
      enter_cyc = -1; exit_cyc = -1; tmo_cyc = -1; busy_rise_cyc = -1;
      st_q.delete();
      st_cyc_q.delete();
   endtask

   // Changes the beams just after a rising edge and holds them n cycles.
   task automatic drive(input logic o, input logic i, input int n, output int edge_cyc);
      @(posedge clk);
      #1;
      beam_outer = o;
      beam_inner = i;
      edge_cyc = cyc;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({enter_pulse, exit_pulse, busy, timeout_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000",
                  {enter_pulse, exit_pulse, busy, timeout_err});
      end
      checks++;
      if (dbg_state !== S_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
      end
      reset = 1'b0;
      prev_state = S_IDLE;
      busy_prev = 1'b0;
   endtask

   task automatic test_entry();
      int k, kf;
      clear_mon();
      drive(1'b1, 1'b0, 10, k);
      drive(1'b1, 1'b1, 10, k);
      drive(1'b0, 1'b1, 10, k);
      drive(1'b0, 1'b0, 20, kf);
      @(negedge clk);
      checks++;
      if (enter_cnt !== 1) begin
         errors++;
         $display("FAIL entry_count: got %0d expected 1", enter_cnt);
      end
      checks++;
      if (enter_cyc - kf !== 7) begin
         errors++;
         $display("FAIL entry_latency: got %0d expected 7", enter_cyc - kf);
      end
      checks++;
      if (exit_cnt !== 0 || both_cnt !== 0) begin
         errors++;
         $display("FAIL entry_no_exit: got exit=%0d both=%0d expected 0 0", exit_cnt, both_cnt);
      end
      checks++;
      if (dbg_state !== S_IDLE || busy !== 1'b0) begin
         errors++;
         $display("FAIL entry_end_idle: got state=%0d busy=%b expected 0 0", dbg_state, busy);
      end
   endtask

   task automatic test_exit();
      int k0, k, kf;
      clear_mon();
      drive(1'b0, 1'b1, 10, k0);
      drive(1'b1, 1'b1, 10, k);
      drive(1'b1, 1'b0, 10, k);
      drive(1'b0, 1'b0, 20, kf);
      @(negedge clk);
      checks++;
      if (exit_cnt !== 1 || enter_cnt !== 0) begin
         errors++;
         $display("FAIL exit_count: got exit=%0d enter=%0d expected 1 0", exit_cnt, enter_cnt);
      end
      checks++;
      if (exit_cyc - kf !== 7) begin
         errors++;
         $display("FAIL exit_latency: got %0d expected 7", exit_cyc - kf);
      end
      checks++;
      if (st_q.size() < 1 || st_q[0] !== S_X1 || st_cyc_q[0] - k0 !== 7) begin
         errors++;
         $display("FAIL exit_x1_entry: got size=%0d first=%0d expected X1 at +7",
                  st_q.size(), (st_q.size() > 0) ? st_q[0] : 4'hF);
      end
      checks++;
      if (busy_rise_cyc - k0 !== 7) begin
         errors++;
         $display("FAIL exit_busy_rise: got %0d expected 7", busy_rise_cyc - k0);
      end
      checks++;
      if (busy_cnt !== 30) begin
         errors++;
         $display("FAIL exit_busy_span: got %0d cycles expected 30", busy_cnt);
      end
   endtask

   task automatic test_glitch();
      int k;
      clear_mon();
      drive(1'b1, 1'b0, 3, k);
      drive(1'b0, 1'b0, 15, k);
      @(negedge clk);
      checks++;
      if (st_q.size() !== 0) begin
         errors++;
         $display("FAIL glitch_state: got %0d state changes expected 0", st_q.size());
      end
      checks++;
      if (busy_cnt !== 0) begin
         errors++;
         $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_cnt);
      end
      checks++;
      if (enter_cnt + exit_cnt + tmo_cnt !== 0) begin
         errors++;
         $display("FAIL glitch_pulses: got %0d pulses expected 0", enter_cnt + exit_cnt + tmo_cnt);
      end
      checks++;
      if (dut.db !== 2'b00) begin
         errors++;
         $display("FAIL glitch_debounced: got %b expected 00", dut.db);
      end
   endtask

   task automatic test_reversal();
      int k;
      logic [3:0] exp_st [4];
      exp_st = '{S_E1, S_E2, S_E1, S_IDLE};
      clear_mon();
      drive(1'b1, 1'b0, 10, k);
      drive(1'b1, 1'b1, 10, k);
      drive(1'b1, 1'b0, 10, k);
      drive(1'b0, 1'b0, 15, k);
      @(negedge clk);
      checks++;
      if (st_q.size() !== 4) begin
         errors++;
         $display("FAIL reversal_len: got %0d state changes expected 4", st_q.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (st_q[j] !== exp_st[j]) begin
               errors++;
               $display("FAIL reversal_step%0d: got %0d expected %0d", j, st_q[j], exp_st[j]);
            end
         end
      end
      checks++;
      if (enter_cnt + exit_cnt !== 0) begin
         errors++;
         $display("FAIL reversal_pulses: got %0d expected 0", enter_cnt + exit_cnt);
      end
   endtask

   task automatic test_timeout();
      int k, kr;
      clear_mon();
      drive(1'b1, 1'b0, 100, k);
      drive(1'b0, 1'b0, 15, kr);
      @(negedge clk);
      checks++;
      if (tmo_cnt !== 1) begin
         errors++;
         $display("FAIL timeout_count: got %0d expected 1", tmo_cnt);
      end
      checks++;
      if (st_q.size() !== 3) begin
         errors++;
         $display("FAIL timeout_path_len: got %0d expected 3", st_q.size());
      end else begin
         checks++;
         if (st_q[0] !== S_E1 || st_q[1] !== S_WC || st_q[2] !== S_IDLE) begin
            errors++;
            $display("FAIL timeout_path: got %0d,%0d,%0d expected 1,7,0", st_q[0], st_q[1], st_q[2]);
         end
         checks++;
         if (tmo_cyc - st_cyc_q[0] !== 64 || st_cyc_q[1] !== tmo_cyc) begin
            errors++;
            $display("FAIL timeout_timing: got %0d after E1 (wc at %0d, pulse at %0d) expected 64",
                     tmo_cyc - st_cyc_q[0], st_cyc_q[1], tmo_cyc);
         end
         checks++;
         if (st_cyc_q[2] - kr !== 7) begin
            errors++;
            $display("FAIL timeout_release: got %0d expected 7", st_cyc_q[2] - kr);
         end
      end
      checks++;
      if (enter_cnt + exit_cnt !== 0) begin
         errors++;
         $display("FAIL timeout_pulses: got %0d expected 0", enter_cnt + exit_cnt);
      end
   endtask

   task automatic test_reset_in_e3();
      int k;
      clear_mon();
      drive(1'b1, 1'b0, 10, k);
      drive(1'b1, 1'b1, 10, k);
      drive(1'b0, 1'b1, 10, k);
      @(negedge clk);
      checks++;
      if (dbg_state !== S_E3) begin
         errors++;
         $display("FAIL reset_e3_reached: got %0d expected %0d", dbg_state, S_E3);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      beam_outer = 1'b0;
      beam_inner = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      checks++;
      if (enter_cnt !== 0 || exit_cnt !== 0) begin
         errors++;
         $display("FAIL reset_e3_pulse: got enter=%0d exit=%0d expected 0 0", enter_cnt, exit_cnt);
      end
      checks++;
      if ({enter_pulse, exit_pulse, busy, timeout_err} !== 4'b0000 || dbg_state !== S_IDLE) begin
         errors++;
         $display("FAIL reset_e3_outputs: got %b state=%0d expected 0000 state=0",
                  {enter_pulse, exit_pulse, busy, timeout_err}, dbg_state);
      end
   endtask

   task automatic test_held_broken();
      int k;
      clear_mon();
      @(posedge clk);
      #1;
      reset = 1'b1;
      beam_outer = 1'b1;
      beam_inner = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      checks++;
      if (dbg_state !== S_WC || busy !== 1'b1) begin
         errors++;
         $display("FAIL held_wait_clear: got state=%0d busy=%b expected 7 1", dbg_state, busy);
      end
      drive(1'b0, 1'b0, 12, k);
      @(negedge clk);
      checks++;
      if (dbg_state !== S_IDLE) begin
         errors++;
         $display("FAIL held_release: got %0d expected 0", dbg_state);
      end
      checks++;
      if (enter_cnt + exit_cnt + tmo_cnt !== 0) begin
         errors++;
         $display("FAIL held_pulses: got %0d expected 0", enter_cnt + exit_cnt + tmo_cnt);
      end
   endtask

   initial begin
      prev_state = S_IDLE;
      busy_prev = 1'b0;
      clear_mon();
      test_reset();
      test_entry();
      test_exit();
      test_glitch();
      test_reversal();
      test_timeout();
      test_reset_in_e3();
      test_held_broken();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/door_direction_detector.md
DOOR_DIRECTION_DETECTOR -- requirements
Module: door_direction_detector

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a beam change is accepted (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: maximum consecutive cycles allowed outside IDLE (legal range 4*DEBOUNCE_CYCLES..65535).
REQ-003 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port beam_outer, input, 1 bit: raw outer door beam, asynchronous, 1 = broken.
REQ-006 SHALL have port beam_inner, input, 1 bit: raw inner door beam, asynchronous, 1 = broken.
REQ-007 SHALL have port enter_pulse, output, 1 bit: one-cycle pulse per completed entry; drives the room counter increment input.
REQ-008 SHALL have port exit_pulse, output, 1 bit: one-cycle pulse per completed exit; drives the room counter decrement input.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a sequence is abandoned on timeout.

Function
REQ-011 SHALL pass each beam input through a dedicated 2-flop synchronizer before any other logic uses it.
REQ-012 SHALL debounce each synchronized beam independently: the debounced value takes the synchronized value on the edge where the two have differed for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears that beam's counter.
REQ-013 SHALL define pair P = {outer_db, inner_db}; the FSM evaluates P once per cycle.
REQ-014 SHALL implement the FSM states IDLE, E1, E2, E3, X1, X2, X3, WAIT_CLEAR.
REQ-015 From IDLE: P=10 -> E1, P=01 -> X1, P=11 -> WAIT_CLEAR, P=00 -> stay.
REQ-016 From E1: 11 -> E2, 00 -> IDLE (abort, no pulse), 01 -> WAIT_CLEAR.
REQ-017 From E2: 01 -> E3, 10 -> E1 (backing out), 00 -> IDLE (no pulse).
REQ-018 From E3: 00 -> IDLE with enter_pulse=1 on the next cycle, 11 -> E2, 10 -> WAIT_CLEAR.
REQ-019 From X1/X2/X3, the transitions SHALL mirror E1/E2/E3 with outer and inner swapped, and X3 with P=00 -> IDLE with exit_pulse=1.
REQ-020 From WAIT_CLEAR: P=00 -> IDLE (no pulse); any other P -> stay.
REQ-021 The FSM SHALL self-transition whenever P is unchanged, except as stated in REQ-022.
REQ-022 SHALL provide a 16-bit dwell counter that clears on every state change and in IDLE; on reaching TIMEOUT_CYCLES in any state other than IDLE or WAIT_CLEAR, the FSM SHALL go to WAIT_CLEAR and pulse timeout_err for one cycle.
REQ-023 All outputs SHALL be registered; enter_pulse and exit_pulse SHALL never be high in the same cycle and SHALL each be exactly one cycle wide.
REQ-024 End-to-end latency from a stable raw edge completing a valid sequence to its pulse SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-025 Unreachable state encodings SHALL recover to IDLE on the next cycle with no pulse.
REQ-026 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-027 While reset is high: synchronizers and debounced values = 0, debounce and dwell counters = 0, state = IDLE, and enter_pulse, exit_pulse, busy and timeout_err = 0.
REQ-028 Reset asserted mid-sequence SHALL discard the sequence without emitting a pulse; after deassertion, detection restarts from IDLE.
REQ-029 After reset deassertion, beams held broken SHALL be seen as 11 and SHALL lead to WAIT_CLEAR, not to a pulse.

Verification (bench: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-030 Entry: raw P steps 10, 11, 01, 00, each held 10 cycles -> exactly one enter_pulse, 7 cycles after the final 00 edge; exit_pulse stays 0.
REQ-031 Exit: raw P steps 01, 11, 10, 00, each held 10 cycles -> exactly one exit_pulse; busy is high from the X1 transition until the pulse cycle.
REQ-032 Glitch: beam_outer high for 3 cycles, then low -> debounced value unchanged, state stays IDLE, no pulses.
REQ-033 Reversal: raw P steps 10, 11, 10, 00 -> FSM visits E1, E2, E1, IDLE with no pulse.
REQ-034 Timeout: P=10 held 100 cycles -> timeout_err pulses once 64 cycles after E1 entry, FSM goes to WAIT_CLEAR, and returns to IDLE 7 cycles after release with no pulse.
REQ-035 Reset in E3: reset asserted for 2 cycles, then P=00 -> no enter_pulse, all outputs 0, state IDLE.
